// File: rtl/mp_add_seq_pkg.sv
// Shared types and constants for the byte-serial multi-precision adder.
package mp_add_seq_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla_8bit.sv
// 8-bit carry-lookahead adder built from two 4-bit lookahead groups.
module cla_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);

  logic [7:0] g;
  logic [7:0] p;
  logic [3:0] lo_c;
  logic [3:0] hi_c;

  // Returns carries out of bits 0..3 of a 4-bit group.
  function automatic logic [3:0] cla4(input logic [3:0] gg, input logic [3:0] pp, input logic c0);
    logic [3:0] c;
    c[0] = gg[0] | (pp[0] & c0);
    c[1] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c0);
    c[2] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0]) | (pp[2] & pp[1] & pp[0] & c0);
    c[3] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1]) | (pp[3] & pp[2] & pp[1] & gg[0])
         | (pp[3] & pp[2] & pp[1] & pp[0] & c0);
    return c;
  endfunction

  assign g    = a & b;
  assign p    = a ^ b;
  assign lo_c = cla4(g[3:0], p[3:0], cin);
  assign hi_c = cla4(g[7:4], p[7:4], lo_c[3]);
  assign s    = p ^ {hi_c[2:0], lo_c, cin};
  assign cout = hi_c[3];

endmodule

// File: rtl/mp_add_seq.sv
// Byte-serial multi-precision adder: one byte per cycle through a shared cla_8bit slice.
// Optional subtract mode (sub port, operand inversion) enabled by defining SEQ_ADD_SUB_EN.
module mp_add_seq
  import mp_add_seq_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BYTE_W*NBYTES-1:0] a,
  input  logic [BYTE_W*NBYTES-1:0] b,
  input  logic                     cin,
`ifdef SEQ_ADD_SUB_EN
  input  logic                     sub,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BYTE_W*NBYTES-1:0] sum,
  output logic                     cout,
  output logic                     ovf,
  output logic                     zero
);

  localparam int unsigned IDX_W = $clog2(NBYTES);
  localparam int unsigned LAST  = NBYTES - 1;

  state_t state_q;
  state_t state_d;

  logic [NBYTES-1:0][BYTE_W-1:0] a_q;
  logic [NBYTES-1:0][BYTE_W-1:0] b_q;
  logic [NBYTES-1:0][BYTE_W-1:0] sum_q;
  logic [NBYTES-1:0][BYTE_W-1:0] sum_full;
  logic [BYTE_W*NBYTES-1:0]      b_in;
  logic                          cin_in;
  logic                          cin_q;
  logic                          carry_q;
  logic [IDX_W-1:0]              idx_q;
  logic                          last;
  logic [BYTE_W-1:0]             slice_s;
  logic                          slice_c;
  logic                          slice_cin;

  // Operand conditioning: subtract is a + ~b + ~cin.
`ifdef SEQ_ADD_SUB_EN
  assign b_in   = sub ? ~b : b;
  assign cin_in = sub ? ~cin : cin;
`else
  assign b_in   = b;
  assign cin_in = cin;
`endif

  assign last      = (idx_q == IDX_W'(LAST));
  assign slice_cin = (idx_q == '0) ? cin_q : carry_q;

  cla_8bit u_slice (
    .a    (a_q[idx_q]),
    .b    (b_q[idx_q]),
    .cin  (slice_cin),
    .s    (slice_s),
    .cout (slice_c)
  );

  always_comb begin
    sum_full        = sum_q;
    sum_full[idx_q] = slice_s;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid && in_ready) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      cin_q     <= 1'b0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      sum_q     <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else begin
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q   <= a;
            b_q   <= b_in;
            cin_q <= cin_in;
            idx_q <= '0;
          end
        end
        RUN: begin
          sum_q[idx_q] <= slice_s;
          carry_q      <= slice_c;
          if (!last) begin
            idx_q <= idx_q + IDX_W'(1);
          end else begin
            cout <= slice_c;
            ovf  <= (a_q[LAST][BYTE_W-1] == b_q[LAST][BYTE_W-1]) &&
                    (slice_s[BYTE_W-1] != a_q[LAST][BYTE_W-1]);
            zero <= ~|sum_full;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum = sum_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed self-checking bench for mp_add_seq (NBYTES=4).
module tb_mp_add_seq;

  localparam int unsigned NBYTES = 4;
  localparam int unsigned W      = 8 * NBYTES;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef SEQ_ADD_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mp_add_seq #(.NBYTES(NBYTES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SEQ_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  // Offers one operand pair and waits (bounded) for out_valid; leaves the result unconsumed.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv, input logic sv,
                        output int lat, output logic got);
    @(negedge clk);
    a = av; b = bv; cin = cv;
`ifdef SEQ_ADD_SUB_EN
    sub = sv;
`else
    if (sv) $display("note: sub requested without subtract support");
`endif
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (sum !== 32'h0) begin fails++; $display("FAIL reset_sum got %h want 0", sum); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if ({cout, ovf, zero} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b want 000", {cout, ovf, zero}); end
  endtask

  task automatic test_carry_chain();
    int lat; logic got;
    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, lat, got);
    checks++; if (got !== 1'b1) begin fails++; $display("FAIL chain_timeout got %b want 1", got); end
    checks++; if (lat !== 4) begin fails++; $display("FAIL chain_latency got %0d want 4", lat); end
    checks++; if (sum !== 32'h0000_0100) begin fails++; $display("FAIL chain_sum got %h want 00000100", sum); end
    checks++; if ({cout, ovf, zero} !== 3'b000) begin fails++; $display("FAIL chain_flags got %b want 000", {cout, ovf, zero}); end
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL chain_busy got %b want 0", in_ready); end
    consume();
    @(negedge clk);
    checks++; if ({in_ready, out_valid} !== 2'b10) begin fails++; $display("FAIL chain_release got %b want 10", {in_ready, out_valid}); end
    run_op(32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, lat, got);
    checks++; if ({got, sum, cout} !== {1'b1, 32'h0001_0000, 1'b0}) begin fails++; $display("FAIL chain_cin got %b/%h/%b want 1/00010000/0", got, sum, cout); end
    consume();
  endtask

  task automatic test_wrap();
    int lat; logic got;
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat, got);
    checks++; if (sum !== 32'h0) begin fails++; $display("FAIL wrap_sum got %h want 0", sum); end
    checks++; if ({cout, zero, ovf} !== 3'b110) begin fails++; $display("FAIL wrap_flags got %b want 110", {cout, zero, ovf}); end
    consume();
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat, got);
    checks++; if (sum !== 32'h8000_0000) begin fails++; $display("FAIL posovf_sum got %h want 80000000", sum); end
    checks++; if ({cout, zero, ovf} !== 3'b001) begin fails++; $display("FAIL posovf_flags got %b want 001", {cout, zero, ovf}); end
    consume();
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, lat, got);
    checks++; if ({sum, cout, zero, ovf} !== {32'h0, 3'b111}) begin fails++; $display("FAIL negovf got %h/%b want 0/111", sum, {cout, zero, ovf}); end
    consume();
  endtask

  task automatic test_back_to_back();
    int lat; logic got;
    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, lat, got);
    checks++; if (sum !== 32'h2345_6789) begin fails++; $display("FAIL bp_first got %h want 23456789", sum); end
    a = 32'h1; b = 32'h2; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, sum} !== {2'b10, 32'h2345_6789}) begin
        fails++; $display("FAIL bp_hold%0d got %b/%h want 10/23456789", i, {out_valid, in_ready}, sum);
      end
    end
    a = 32'h10; b = 32'h20; out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    checks++; if ({in_ready, out_valid} !== 2'b10) begin fails++; $display("FAIL bp_idle got %b want 10", {in_ready, out_valid}); end
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0; got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (out_valid) begin got = 1'b1; break; end
    end
    checks++; if ({got, lat} !== {1'b1, 32'd4}) begin fails++; $display("FAIL bp_second_lat got %b/%0d want 1/4", got, lat); end
    checks++; if (sum !== 32'h0000_0030) begin fails++; $display("FAIL bp_second_sum got %h want 00000030", sum); end
    consume();
  endtask

  task automatic test_reset_mid_run();
    int lat; logic got; logic seen;
    @(negedge clk);
    a = 32'h0101_0101; b = 32'h0101_0101; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if ({in_ready, out_valid} !== 2'b10) begin fails++; $display("FAIL midrst_state got %b want 10", {in_ready, out_valid}); end
    checks++; if (sum !== 32'h0) begin fails++; $display("FAIL midrst_sum got %h want 0", sum); end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin fails++; $display("FAIL midrst_no_valid got %b want 0", seen); end
    run_op(32'h3, 32'h4, 1'b0, 1'b0, lat, got);
    checks++; if ({got, sum} !== {1'b1, 32'h7}) begin fails++; $display("FAIL midrst_recover got %b/%h want 1/00000007", got, sum); end
    consume();
  endtask

`ifdef SEQ_ADD_SUB_EN
  task automatic test_sub();
    int lat; logic got;
    run_op(32'h5, 32'h7, 1'b0, 1'b1, lat, got);
    checks++; if ({sum, cout} !== {32'hFFFF_FFFE, 1'b0}) begin fails++; $display("FAIL sub_neg got %h/%b want FFFFFFFE/0", sum, cout); end
    consume();
    run_op(32'h7, 32'h5, 1'b0, 1'b1, lat, got);
    checks++; if ({sum, cout, ovf} !== {32'h2, 2'b10}) begin fails++; $display("FAIL sub_pos got %h/%b want 00000002/10", sum, {cout, ovf}); end
    consume();
    sub = 1'b0;
  endtask
`endif

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
`ifdef SEQ_ADD_SUB_EN
    sub = 1'b0;
`endif
    test_reset();
    test_carry_chain();
    test_wrap();
    test_back_to_back();
    test_reset_mid_run();
`ifdef SEQ_ADD_SUB_EN
    test_sub();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
